// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : N-port arbiter in front of a single-ported word memory with a
//            pipelined, port-tagged read return path.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int N_PORTS   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int RD_LAT    = 1,
    parameter int ARB_MODE  = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [N_PORTS-1:0]             i_req,
    input  logic [N_PORTS-1:0]             i_we,
    input  logic [N_PORTS*ADDR_W-1:0]      i_addr,
    input  logic [N_PORTS*DATA_W-1:0]      i_wdata,
    input  logic [N_PORTS*(DATA_W/8)-1:0]  i_be,
    output logic [N_PORTS-1:0]             o_gnt,
    output logic [N_PORTS-1:0]             o_rvalid,
    output logic [DATA_W-1:0]              o_rdata,
    output logic                           o_busy
);

    localparam int c_NB    = DATA_W / 8;
    localparam int c_BOFF  = $clog2(c_NB);
    localparam int c_IDX_W = $clog2(MEM_WORDS);
    localparam int c_PID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [c_PID_W-1:0] r_ptr;
    logic [DATA_W-1:0]  r_mem   [MEM_WORDS];
    logic [RD_LAT-1:0]  r_pv;
    logic [c_PID_W-1:0] r_pid   [RD_LAT];
    logic [DATA_W-1:0]  r_pdata [RD_LAT];

    logic [c_PID_W-1:0] w_start;
    logic               w_hi_any;
    logic [c_PID_W-1:0] w_hi_idx;
    logic               w_lo_any;
    logic [c_PID_W-1:0] w_lo_idx;
    logic               w_any;
    logic [c_PID_W-1:0] w_gidx;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic [c_NB-1:0]    w_be;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_rd_acc;
    logic               w_wr_acc;

    assign w_start = (ARB_MODE == 1) ? r_ptr : '0;

    // Winner is the lowest requester at/after w_start, else the lowest overall (wrap).
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (i_req[p]) begin
                w_lo_any = 1'b1;
                w_lo_idx = c_PID_W'(p);
                if (p >= int'(w_start)) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = c_PID_W'(p);
                end
            end
        end
        w_any  = w_lo_any;
        w_gidx = w_hi_any ? w_hi_idx : w_lo_idx;
        o_gnt  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            o_gnt[p] = w_any && (w_gidx == c_PID_W'(p));
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (o_gnt[p]) begin
                w_we    = i_we[p];
                w_addr  = i_addr[p*ADDR_W +: ADDR_W];
                w_wdata = i_wdata[p*DATA_W +: DATA_W];
                w_be    = i_be[p*c_NB +: c_NB];
            end
        end
    end

    assign w_idx    = w_addr[c_BOFF +: c_IDX_W];
    assign w_wr_acc = w_any & w_we;
    assign w_rd_acc = w_any & ~w_we;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if ((ARB_MODE == 1) && w_any) begin
            r_ptr <= (w_gidx == c_PID_W'(N_PORTS - 1)) ? '0 : w_gidx + 1'b1;
        end
    end

    // Storage is deliberately not reset; the reset term only blocks accepts.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc && !i_rst) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Data/tag stages only load behind a valid, so the last stage holds between responses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pv <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_pid[s]   <= '0;
                r_pdata[s] <= '0;
            end
        end else begin
            r_pv[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_pid[0]   <= w_gidx;
                r_pdata[0] <= r_mem[w_idx];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                if (r_pv[s-1]) begin
                    r_pid[s]   <= r_pid[s-1];
                    r_pdata[s] <= r_pdata[s-1];
                end
            end
        end
    end

    always_comb begin
        o_rvalid = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            o_rvalid[p] = r_pv[RD_LAT-1] && (r_pid[RD_LAT-1] == c_PID_W'(p));
        end
    end

    assign o_rdata = r_pdata[RD_LAT-1];
    assign o_busy  = |r_pv;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mem_port_arbiter: fixed-priority N=2/RD_LAT=1 and round-robin N=3/RD_LAT=3
// instances, with a read-response scoreboard per instance.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t qf[$];
    exp_t qr[$];
    exp_t ef;
    exp_t er;

    // Fixed-priority instance
    logic        f_rst = 1'b1;
    logic [1:0]  f_req = '0, f_we = '0, f_gnt, f_rvalid;
    logic [63:0] f_addr = '0, f_wdata = '0;
    logic [7:0]  f_be = '0;
    logic [31:0] f_rdata;
    logic        f_busy;

    // Round-robin instance
    logic        r_rst = 1'b1;
    logic [2:0]  r_req = '0, r_we = '0, r_gnt, r_rvalid;
    logic [95:0] r_addr = '0, r_wdata = '0;
    logic [11:0] r_be = '0;
    logic [31:0] r_rdata;
    logic        r_busy;

    mem_port_arbiter #(
        .N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .RD_LAT(1), .ARB_MODE(0)
    ) dut_f (
        .i_clk(clk), .i_rst(f_rst), .i_req(f_req), .i_we(f_we), .i_addr(f_addr),
        .i_wdata(f_wdata), .i_be(f_be), .o_gnt(f_gnt), .o_rvalid(f_rvalid),
        .o_rdata(f_rdata), .o_busy(f_busy)
    );

    mem_port_arbiter #(
        .N_PORTS(3), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024), .RD_LAT(3), .ARB_MODE(1)
    ) dut_r (
        .i_clk(clk), .i_rst(r_rst), .i_req(r_req), .i_we(r_we), .i_addr(r_addr),
        .i_wdata(r_wdata), .i_be(r_be), .o_gnt(r_gnt), .o_rvalid(r_rvalid),
        .o_rdata(r_rdata), .o_busy(r_busy)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Response monitors
    always @(negedge clk) begin
        if (f_rvalid != 2'b00) begin
            if (qf.size() == 0) begin
                chk("f_unexpected_rvalid", f_rvalid, 0);
            end else begin
                ef = qf.pop_front();
                chk("f_rvalid_port", f_rvalid, 64'(1 << ef.port));
                chk("f_rdata", f_rdata, ef.data);
                chk("f_latency", cyc, ef.due);
            end
        end else if (qf.size() != 0 && qf[0].due < cyc) begin
            ef = qf.pop_front();
            chk("f_missing_rvalid", f_rvalid, 64'(1 << ef.port));
        end
    end

    always @(negedge clk) begin
        if (r_rvalid != 3'b000) begin
            if (qr.size() == 0) begin
                chk("r_unexpected_rvalid", r_rvalid, 0);
            end else begin
                er = qr.pop_front();
                chk("r_rvalid_port", r_rvalid, 64'(1 << er.port));
                chk("r_rdata", r_rdata, er.data);
                chk("r_latency", cyc, er.due);
            end
        end else if (qr.size() != 0 && qr[0].due < cyc) begin
            er = qr.pop_front();
            chk("r_missing_rvalid", r_rvalid, 64'(1 << er.port));
        end
    end

    task automatic f_op(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        f_req = '0;
        f_req[p] = 1'b1;
        f_we[p] = we;
        f_addr[p*32 +: 32] = a;
        f_wdata[p*32 +: 32] = d;
        f_be[p*4 +: 4] = be;
        if (!we) begin
            e.port = p; e.data = exp; e.due = cyc + 1;
            qf.push_back(e);
        end
        #1 chk("f_gnt_single", f_gnt, 64'(1 << p));
        @(posedge clk);
    endtask

    task automatic r_op(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] exp, input bit expect_resp);
        exp_t e;
        @(negedge clk);
        r_req = '0;
        r_req[p] = 1'b1;
        r_we[p] = we;
        r_addr[p*32 +: 32] = a;
        r_wdata[p*32 +: 32] = d;
        r_be[p*4 +: 4] = be;
        if (!we && expect_resp) begin
            e.port = p; e.data = exp; e.due = cyc + 3;
            qr.push_back(e);
        end
        #1 chk("r_gnt_single", r_gnt, 64'(1 << p));
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("f_reset_rvalid", f_rvalid, 0);
        chk("f_reset_rdata", f_rdata, 0);
        chk("f_reset_busy", f_busy, 0);
        chk("r_reset_rvalid", r_rvalid, 0);
        chk("r_reset_rdata", r_rdata, 0);
        chk("r_reset_busy", r_busy, 0);
        f_req = 2'b11;
        #1 chk("f_gnt_in_reset", f_gnt, 2'b01);
        f_req = '0;
        f_rst = 1'b0;
        r_rst = 1'b0;

        // Fixed priority: write, read-after-write, byte enables, aliasing
        f_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
        f_op(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);
        f_op(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0);
        f_op(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0);
        f_op(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD);
        f_op(0, 1'b0, 32'h1013, 32'h0, 4'h0, 32'hDEADBEEF);

        // Contention: port 0 starves port 1 until it drops
        f_we = 2'b00;
        f_addr = {32'h20, 32'h10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            f_req = 2'b11;
            e.port = 0; e.data = 32'hDEADBEEF; e.due = cyc + 1;
            qf.push_back(e);
            #1 chk("f_contention_gnt", f_gnt, 2'b01);
        end
        @(negedge clk);
        f_req = 2'b10;
        e.port = 1; e.data = 32'h11BB33DD; e.due = cyc + 1;
        qf.push_back(e);
        #1 chk("f_drop_p0_gnt", f_gnt, 2'b10);
        @(negedge clk);
        f_req = '0;

        // Round-robin rotation, all ports writing distinct words
        for (int p = 0; p < 3; p++) begin
            r_we[p] = 1'b1;
            r_addr[p*32 +: 32] = 32'h200 + 32'(4 * p);
            r_wdata[p*32 +: 32] = 32'hA0 + 32'(p);
            r_be[p*4 +: 4] = 4'hF;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r_req = 3'b111;
            #1 chk("r_rr_gnt", r_gnt, 64'(1 << (i % 3)));
        end
        @(negedge clk);
        r_req = 3'b010;
        #1 chk("r_rr_alone_gnt", r_gnt, 3'b010);
        @(negedge clk);
        r_req = 3'b111;
        #1 chk("r_rr_after_alone_gnt", r_gnt, 3'b100);
        @(negedge clk);
        r_req = '0;

        // Pipelined reads with RD_LAT=3
        r_op(0, 1'b1, 32'h0, 32'd1, 4'hF, 32'h0, 1'b0);
        r_op(0, 1'b1, 32'h4, 32'd2, 4'hF, 32'h0, 1'b0);
        r_op(0, 1'b1, 32'h8, 32'd3, 4'hF, 32'h0, 1'b0);
        r_op(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'd1, 1'b1);
        r_op(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'd2, 1'b1);
        r_op(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'd3, 1'b1);
        @(negedge clk);
        r_req = '0;
        chk("r_busy_pipe0", r_busy, 1);
        @(negedge clk);
        chk("r_busy_pipe1", r_busy, 1);
        @(negedge clk);
        chk("r_busy_pipe2", r_busy, 1);
        @(negedge clk);
        chk("r_busy_idle", r_busy, 0);

        // Reset one cycle after a read accept discards it and clears the pointer
        r_op(1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        r_req = '0;
        @(negedge clk);
        r_rst = 1'b1;
        #1;
        chk("r_rst_rvalid", r_rvalid, 0);
        chk("r_rst_busy", r_busy, 0);
        chk("r_rst_rdata", r_rdata, 0);
        repeat (3) @(negedge clk);
        r_rst = 1'b0;
        @(negedge clk);
        chk("r_post_rst_busy", r_busy, 0);
        r_we = 3'b000;
        r_addr[31:0] = 32'h4;
        r_req = 3'b111;
        e.port = 0; e.data = 32'd2; e.due = cyc + 3;
        qr.push_back(e);
        #1 chk("r_post_rst_ptr_gnt", r_gnt, 3'b001);
        r_op(1, 1'b0, 32'h0, 32'h0, 4'h0, 32'd1, 1'b1);
        r_op(2, 1'b0, 32'h8, 32'h0, 4'h0, 32'd3, 1'b1);
        r_op(2, 1'b0, 32'h208, 32'h0, 4'h0, 32'hA2, 1'b1);
        @(negedge clk);
        r_req = '0;

        for (int i = 0; i < 20; i++) begin
            if (qf.size() == 0 && qr.size() == 0) break;
            @(negedge clk);
        end
        chk("f_queue_drained", qf.size(), 0);
        chk("r_queue_drained", qr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
